bank_txn_scheduler: RTL

- Shares one bank transaction datapath between N requesters (teller/ATM ports).
- Arbitrates round-robin, latches the winning request, and drives the datapath's operation/amount/account_id inputs.
- Issues a one-cycle start, waits for done or timeout, then returns balance and status to the winning requester.
- Sits between the requester front-ends and the single bank datapath instance.

---
 rtl/bank_pkg.sv | 41 ++++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/bank_txn_scheduler.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/bank_pkg.sv
// Shared definitions for the bank transaction scheduler.
// Holds opcode and status encodings, FSM state encoding, datapath widths,
// the latched-transaction record and the opcode legality check.
package bank_pkg;

  localparam int unsigned OP_W   = 3;
  localparam int unsigned AMT_W  = 32;
  localparam int unsigned ACCT_W = 8;
  localparam int unsigned ST_W   = 2;

  // Opcodes; 3'b100..3'b111 are illegal and rejected without touching the bank.
  localparam logic [OP_W-1:0] OP_BALANCE  = 3'b000;
  localparam logic [OP_W-1:0] OP_WITHDRAW = 3'b001;
  localparam logic [OP_W-1:0] OP_TRANSFER = 3'b010;
  localparam logic [OP_W-1:0] OP_DEPOSIT  = 3'b011;

  // Response status codes.
  localparam logic [ST_W-1:0] ST_OK       = 2'b00;
  localparam logic [ST_W-1:0] ST_REJECT   = 2'b01;
  localparam logic [ST_W-1:0] ST_TIMEOUT  = 2'b10;
  localparam logic [ST_W-1:0] ST_BANK_ERR = 2'b11;

  // Scheduler FSM encoding.
  localparam logic [1:0] FSM_IDLE  = 2'd0;
  localparam logic [1:0] FSM_ISSUE = 2'd1;
  localparam logic [1:0] FSM_WAIT  = 2'd2;
  localparam logic [1:0] FSM_RESP  = 2'd3;

  // Command latched from the winning requester and presented to the datapath.
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [AMT_W-1:0]  amount;
    logic [ACCT_W-1:0] account;
  } txn_t;

  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return (op == OP_BALANCE) || (op == OP_WITHDRAW) ||
           (op == OP_TRANSFER) || (op == OP_DEPOSIT);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Grants the first asserted request found searching upward from ptr_i,
// wrapping modulo NUM_REQ.
//   req_i      request vector
//   ptr_i      highest-priority index for this decision
//   gnt_o      one-hot grant (all zero when no request)
//   gnt_idx_o  binary index of the granted requester
//   valid_o    at least one request present
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               valid_o
);

  logic        found;
  int unsigned j;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    j         = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      j = (32'(ptr_i) + i) % NUM_REQ;
      if (!found && req_i[j]) begin
        found     = 1'b1;
        gnt_o[j]  = 1'b1;
        gnt_idx_o = IDX_W'(j);
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/bank_txn_scheduler.sv
// Bank transaction scheduler: shares one bank datapath between NUM_REQ requesters.
// Arbitrates round-robin, latches the winner's command onto bank_*, strobes
// bank_start, waits for bank_done or a timeout, then returns balance/status to
// the winner and holds it until accepted.
//   req_valid/req_ready/req_op/req_amount/req_account  requester command side
//   rsp_valid/rsp_ready/rsp_balance/rsp_status          requester response side
//   bank_operation/bank_amount/bank_account_id/bank_start  datapath command
//   bank_done/bank_balance/bank_error                   datapath completion
module bank_txn_scheduler
  import bank_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [OP_W*NUM_REQ-1:0]   req_op,
  input  logic [AMT_W*NUM_REQ-1:0]  req_amount,
  input  logic [ACCT_W*NUM_REQ-1:0] req_account,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [AMT_W-1:0]          rsp_balance,
  output logic [ST_W-1:0]           rsp_status,
  output logic [OP_W-1:0]           bank_operation,
  output logic [AMT_W-1:0]          bank_amount,
  output logic [ACCT_W-1:0]         bank_account_id,
  output logic                      bank_start,
  input  logic                      bank_done,
  input  logic [AMT_W-1:0]          bank_balance,
  input  logic                      bank_error
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = 8;

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  txn_t               txn_q, txn_d;
  logic               bank_start_q, bank_start_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [AMT_W-1:0]   rsp_balance_q, rsp_balance_d;
  logic [ST_W-1:0]    rsp_status_q, rsp_status_d;
  logic [NUM_REQ-1:0] req_ready_c;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;
  txn_t               sel_txn;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req_i     (req_valid),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx),
    .valid_o   (arb_valid)
  );

  // Command fields of the current arbitration winner.
  always_comb begin
    sel_txn.op      = req_op[OP_W*arb_idx +: OP_W];
    sel_txn.amount  = req_amount[AMT_W*arb_idx +: AMT_W];
    sel_txn.account = req_account[ACCT_W*arb_idx +: ACCT_W];
  end

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    gnt_d         = gnt_q;
    cnt_d         = cnt_q;
    txn_d         = txn_q;
    bank_start_d  = 1'b0;
    rsp_valid_d   = rsp_valid_q;
    rsp_balance_d = rsp_balance_q;
    rsp_status_d  = rsp_status_q;
    req_ready_c   = '0;

    case (state_q)
      FSM_IDLE: begin
        if (arb_valid) begin
          req_ready_c = arb_gnt;
          txn_d       = sel_txn;
          gnt_d       = arb_gnt;
          rr_ptr_d    = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
          if (op_is_legal(sel_txn.op)) begin
            bank_start_d = 1'b1;
            state_d      = FSM_ISSUE;
          end else begin
            // Illegal opcodes never reach the datapath.
            rsp_valid_d   = arb_gnt;
            rsp_balance_d = '0;
            rsp_status_d  = ST_REJECT;
            state_d       = FSM_RESP;
          end
        end
      end

      FSM_ISSUE: begin
        cnt_d   = '0;
        state_d = FSM_WAIT;
      end

      FSM_WAIT: begin
        cnt_d = cnt_inc;
        // Done is checked first so it wins over a coincident timeout.
        if (bank_done) begin
          rsp_valid_d   = gnt_q;
          rsp_balance_d = bank_balance;
          rsp_status_d  = bank_error ? ST_BANK_ERR : ST_OK;
          state_d       = FSM_RESP;
        end else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
          rsp_valid_d   = gnt_q;
          rsp_balance_d = '0;
          rsp_status_d  = ST_TIMEOUT;
          state_d       = FSM_RESP;
        end
      end

      FSM_RESP: begin
        // rsp_valid_q is one-hot on the winner, so other rsp_ready bits are masked.
        if (|(rsp_valid_q & rsp_ready)) begin
          rsp_valid_d = '0;
          state_d     = FSM_IDLE;
        end
      end

      default: state_d = FSM_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= FSM_IDLE;
      rr_ptr_q      <= '0;
      gnt_q         <= '0;
      cnt_q         <= '0;
      txn_q         <= '0;
      bank_start_q  <= 1'b0;
      rsp_valid_q   <= '0;
      rsp_balance_q <= '0;
      rsp_status_q  <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      gnt_q         <= gnt_d;
      cnt_q         <= cnt_d;
      txn_q         <= txn_d;
      bank_start_q  <= bank_start_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_balance_q <= rsp_balance_d;
      rsp_status_q  <= rsp_status_d;
    end
  end

  // req_ready is combinational from req_valid; force it low while reset is held.
  assign req_ready       = reset ? '0 : req_ready_c;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_balance     = rsp_balance_q;
  assign rsp_status      = rsp_status_q;
  assign bank_operation  = txn_q.op;
  assign bank_amount     = txn_q.amount;
  assign bank_account_id = txn_q.account;
  assign bank_start      = bank_start_q;

endmodule
